// File: rtl/pixel_stream_tx_pkg.sv
// pixel_stream_tx_pkg: shared state enum, beat/address sizing functions and the band-lane validity helper
package pixel_stream_tx_pkg;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
  function automatic int beats_f(input int bands, input int concat);
    return (bands + concat - 1) / concat;
  endfunction
  function automatic int addr_w_f(input int pixels, input int beats);
    return $clog2(pixels * beats);
  endfunction
  function automatic logic lane_on(input int beat, input int k, input int bands, input int concat);
    return beat * concat + k < bands;
  endfunction
endpackage

// File: rtl/pixel_stream_tx_skid_fifo2.sv
// skid_fifo2: 2-entry FIFO with registered head (dout), ports push/pop/flush/din -> dout/valid/count
module skid_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         valid,
  output logic [1:0]   count
);
  logic [W-1:0] tail;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      dout  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      if (pop && count == 2'd2) dout <= tail;
      else if (push && (count == 2'd0 || pop)) dout <= din;
      if (push && (count == 2'd2 || (count == 2'd1 && !pop))) tail <= din;
      count <= count + 2'(push) - 2'(pop);
    end
  assign valid = count != 2'd0;
endmodule

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: streams one image pass from beat-packed memory (mem_rd_en/mem_addr/mem_rd_data) to pixel_out/out_valid/out_ready with per-beat tags; start/abort/busy/pass_done control
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int SPECTRAL_BANDS = 188,
  parameter int IN_WIDTH       = 16,
  parameter int CONCAT         = 4,
  parameter int TOTAL_PIXELS   = 47500,
  localparam int BEATS  = beats_f(SPECTRAL_BANDS, CONCAT),
  localparam int ADDR_W = addr_w_f(TOTAL_PIXELS, BEATS),
  localparam int PW     = $clog2(TOTAL_PIXELS),
  localparam int DW     = CONCAT * IN_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              pass_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DW-1:0]     mem_rd_data,
  output logic [DW-1:0]     pixel_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last_beat,
  output logic              out_last_pixel,
  output logic [PW-1:0]     pixel_index
);
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int FW = DW + PW + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL_PIXELS * BEATS - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [BW-1:0] rd_beat, fl_beat;
  logic [PW-1:0] rd_pix, fl_pix;
  logic inflight, pop, kill;
  logic [1:0] count;
  logic [DW-1:0] masked;
  logic [FW-1:0] fifo_out;
  assign kill      = abort && (state == STREAM || state == DRAIN);
  assign pop       = out_valid && out_ready;
  // credit: occupancy plus the read in flight, less the beat leaving now, must leave room for one more
  assign mem_rd_en = state == STREAM && (3'(count) + 3'(inflight) < 3'd2 + 3'(pop));
  assign mem_addr  = addr;
  assign busy      = state != IDLE;
  assign pass_done = state == DONE;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? STREAM : IDLE;
      STREAM:  state_nx = kill ? IDLE : (mem_rd_en && addr == LAST_ADDR) ? DRAIN : STREAM;
      DRAIN:   state_nx = kill ? IDLE : (!inflight && (count == 2'd0 || (count == 2'd1 && pop))) ? DONE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state    <= IDLE;
      addr     <= '0;
      rd_beat  <= '0;
      rd_pix   <= '0;
      inflight <= 1'b0;
      fl_beat  <= '0;
      fl_pix   <= '0;
    end else begin
      state    <= state_nx;
      inflight <= mem_rd_en && !kill;
      if (mem_rd_en) begin
        fl_beat <= rd_beat;
        fl_pix  <= rd_pix;
      end
      if (state == IDLE && start) begin
        addr    <= '0;
        rd_beat <= '0;
        rd_pix  <= '0;
      end else if (mem_rd_en) begin
        addr    <= addr + ADDR_W'(addr != LAST_ADDR);
        rd_beat <= rd_beat == BW'(BEATS - 1) ? '0 : rd_beat + 1'b1;
        rd_pix  <= rd_pix + PW'(rd_beat == BW'(BEATS - 1));
      end
    end
  always_comb begin
    masked = '0;
    for (int k = 0; k < CONCAT; k++)
      masked[k*IN_WIDTH +: IN_WIDTH] = lane_on(int'(fl_beat), k, SPECTRAL_BANDS, CONCAT) ? mem_rd_data[k*IN_WIDTH +: IN_WIDTH] : '0;
  end
  skid_fifo2 #(.W(FW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .pop   (pop),
    .flush (kill),
    .din   ({fl_pix, fl_beat == BW'(BEATS - 1), fl_pix == PW'(TOTAL_PIXELS - 1), masked}),
    .dout  (fifo_out),
    .valid (out_valid),
    .count (count)
  );
  assign {pixel_index, out_last_beat, out_last_pixel, pixel_out} = fifo_out;
endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb_pixel_stream_tx: table-driven and randomized checks of pixel_stream_tx against a beat-level reference model
module tb_pixel_stream_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic busy, pass_done, mem_rd_en, out_valid, out_last_beat, out_last_pixel;
  logic [3:0] mem_addr;
  logic [63:0] mem_rd_data, pixel_out;
  logic [2:0] pixel_index;
  int errors = 0, checks = 0;
  int exp_idx, rd_exp, occ, occ_max;
  logic stalled;
  logic [63:0] held;
  typedef struct {
    logic start;
    logic ready;
    logic busy;
    logic rd_en;
    logic valid;
    int   lane0;
  } vec_t;
  vec_t tbl[9];

  always #5 clk = ~clk;

  pixel_stream_tx #(.SPECTRAL_BANDS(10), .IN_WIDTH(16), .CONCAT(4), .TOTAL_PIXELS(5)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .pass_done(pass_done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .pixel_out(pixel_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_last_beat(out_last_beat), .out_last_pixel(out_last_pixel), .pixel_index(pixel_index)
  );

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = 16'(a * 256 + k + 1);
    return w;
  endfunction

  function automatic logic [63:0] exp_word(input int j);
    logic [63:0] w;
    for (int k = 0; k < 4; k++) w[k*16 +: 16] = ((j % 3) * 4 + k < 10) ? 16'(j * 256 + k + 1) : 16'd0;
    return w;
  endfunction

  always @(posedge clk) mem_rd_data <= mem_rd_en ? mem_word(int'(mem_addr)) : {$urandom, $urandom};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic arm();
    exp_idx = 0; rd_exp = 0; occ = 0; occ_max = 0; stalled = 1'b0;
  endtask

  task automatic observe();
    logic p;
    p = out_valid && out_ready;
    if (mem_rd_en) begin
      chk("rd_addr", 64'(mem_addr), 64'(rd_exp));
      rd_exp++;
    end
    if (stalled && out_valid) chk("stall_hold", pixel_out, held);
    if (p) begin
      chk("beat_data", pixel_out, exp_word(exp_idx));
      chk("last_beat", 64'(out_last_beat), 64'(exp_idx % 3 == 2));
      chk("last_pixel", 64'(out_last_pixel), 64'(exp_idx / 3 == 4));
      chk("pixel_index", 64'(pixel_index), 64'(exp_idx / 3));
      exp_idx++;
    end
    occ = occ + int'(mem_rd_en) - int'(p);
    if (occ > occ_max) occ_max = occ;
    stalled = out_valid && !out_ready;
    held = pixel_out;
  endtask

  task automatic step(input logic s, input logic a, input logic r);
    @(negedge clk);
    start = s; abort = a; out_ready = r;
    #1 observe();
  endtask

  task automatic run_to_done(input logic rnd, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      step(1'b0, 1'b0, rnd ? 1'($urandom % 2) : 1'b1);
      if (pass_done) begin
        seen = 1'b1;
        chk("beats_at_done", 64'(exp_idx), 64'd15);
      end
    end
    chk("pass_done_seen", 64'(seen), 64'd1);
    chk("occ_max_le2", 64'(occ_max <= 2), 64'd1);
    step(1'b0, 1'b0, 1'b1);
    chk("busy_after_done", 64'(busy), 64'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_rd_en"}, 64'(mem_rd_en), 64'd0);
    chk({tag, "_done"}, 64'(pass_done), 64'd0);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_data"}, pixel_out, 64'd0);
    chk({tag, "_tags"}, {61'd0, out_last_beat, out_last_pixel, 1'b0} | 64'(pixel_index), 64'd0);
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1};
    tbl[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 2};
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_zero("reset");
    rst = 1'b1;
    // full-rate pass with a start while busy (c5) and in the DONE cycle (c18)
    arm();
    step(1'b1, 1'b0, 1'b1);
    for (int c = 1; c <= 20; c++) begin
      step(c == 5 || c == 18, 1'b0, 1'b1);
      chk($sformatf("full_valid_c%0d", c), 64'(out_valid), 64'(c >= 3 && c <= 17));
      chk($sformatf("full_done_c%0d", c), 64'(pass_done), 64'(c == 18));
      chk($sformatf("full_busy_c%0d", c), 64'(busy), 64'(c <= 18));
    end
    chk("full_beats", 64'(exp_idx), 64'd15);
    chk("full_reads", 64'(rd_exp), 64'd15);
    // stalled start, then release
    arm();
    for (int i = 0; i < 9; i++) begin
      step(tbl[i].start, 1'b0, tbl[i].ready);
      chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].busy));
      chk($sformatf("tbl%0d_rd_en", i), 64'(mem_rd_en), 64'(tbl[i].rd_en));
      chk($sformatf("tbl%0d_valid", i), 64'(out_valid), 64'(tbl[i].valid));
      if (tbl[i].lane0 >= 0) chk($sformatf("tbl%0d_lane0", i), 64'(pixel_out[15:0]), 64'(16'(tbl[i].lane0 * 256 + 1)));
    end
    run_to_done(1'b0, 40);
    // random backpressure
    for (int r = 0; r < 3; r++) begin
      arm();
      step(1'b1, 1'b0, 1'($urandom % 2));
      run_to_done(1'b1, 300);
    end
    // abort at beat 7 under backpressure, with a coincident start
    arm();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 300 && exp_idx < 7; i++) step(1'b0, 1'b0, 1'($urandom % 2));
    chk("reach_beat7", 64'(exp_idx), 64'd7);
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_rd_en", 64'(mem_rd_en), 64'd0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      chk("abort_no_done", 64'(pass_done | out_valid | busy), 64'd0);
    end
    arm();
    step(1'b1, 1'b0, 1'b1);
    run_to_done(1'b0, 40);
    // asynchronous reset mid-pass
    arm();
    step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("pre_reset_valid", 64'(out_valid), 64'd1);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst = 1'b1;
    arm();
    step(1'b1, 1'b0, 1'b1);
    run_to_done(1'b0, 40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pixel_stream_tx.md
Name: pixel_stream_tx

Overview:
- Transmit end of the pixel input stream consumed by the OSP-GA endmember extraction top.
- Reads the hyperspectral cube from beat-packed on-chip memory and drives pixel_out/out_valid (CONCAT bands per beat) with ready backpressure.
- Performs one full image pass per start pulse. OSP-GA rescans the image once per endmember, so start is pulsed once per pass.

Parameters:
- SPECTRAL_BANDS, 188, bands per pixel
- IN_WIDTH, 16, bits per band sample
- CONCAT, 4, bands per beat
- TOTAL_PIXELS, 47500, pixels per image
- BEATS (localparam), ceil(SPECTRAL_BANDS/CONCAT), beats per pixel
- ADDR_W (localparam), clog2(TOTAL_PIXELS*BEATS), memory word address width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle pulse; begins a pass; ignored unless idle
- abort  input  1  terminates the current pass
- busy  output  1  high from the cycle after an accepted start until the pass ends
- pass_done  output  1  one-cycle pulse after the last beat handshakes
- mem_rd_en  output  1  memory read strobe
- mem_addr  output  ADDR_W  word address; pixel p, beat b maps to p*BEATS+b
- mem_rd_data  input  CONCAT*IN_WIDTH  read data, valid exactly 1 cycle after mem_rd_en
- pixel_out  output  CONCAT*IN_WIDTH  beat data; band k of the beat sits at [k*IN_WIDTH +: IN_WIDTH]
- out_valid  output  1  beat valid
- out_ready  input  1  sink ready
- out_last_beat  output  1  current beat is the last beat of its pixel
- out_last_pixel  output  1  current beat belongs to pixel TOTAL_PIXELS-1
- pixel_index  output  clog2(TOTAL_PIXELS)  pixel number of the current beat

Behaviour:
- Reset (rst=0, async): all outputs 0. State IDLE. Counters and FIFO cleared.
- States and transitions:
  - IDLE: start -> STREAM.
  - STREAM: issues reads. After the read of the final address is issued -> DRAIN.
  - DRAIN: no new reads. Once FIFO is empty and there are no in-flight reads -> DONE.
  - DONE: one cycle, pass_done=1 -> IDLE.
- abort in STREAM or DRAIN:
  - Next cycle: mem_rd_en=0, out_valid=0, FIFO flushed, in-flight data discarded, state IDLE.
  - No pass_done is generated. A start in the same cycle as abort is ignored.
- Read issue:
  - Read address counter increments p*BEATS+b sequentially.
  - Credit rule: mem_rd_en=1 only when count + inflight - pop < 2. count = FIFO occupancy (max 2), inflight = read issued last cycle, pop = out_valid & out_ready.
  - This credit rule guarantees the FIFO never overflows.
- Output buffer:
  - 2-entry skid FIFO (registered outputs) written by returning read data.
  - out_valid = FIFO non-empty.
  - pixel_out, out_last_beat, out_last_pixel and pixel_index travel with each entry and are stable while out_valid=1 and out_ready=0.
- Latency:
  - Start pulse at cycle 0: busy=1 and first mem_rd_en at cycle 1, first out_valid at cycle 3.
  - With out_ready held high, throughput is 1 beat/cycle with no bubbles.
- Lane masking: in beat BEATS-1, lanes k where (BEATS-1)*CONCAT+k >= SPECTRAL_BANDS are forced to 0 regardless of memory content.
- Width rule: address counter is ADDR_W wide. The pass ends at address TOTAL_PIXELS*BEATS-1; there is no wrap into a second pass.
- Simultaneous events:
  - pop and push in the same cycle are both honoured.
  - start while busy is ignored; start in the DONE cycle is ignored.
- out_ready may toggle arbitrarily; data is never dropped or duplicated.

Decomposition:
- Shared package: state enum (IDLE, STREAM, DRAIN, DONE), BEATS and ADDR_W derivation functions, lane-extraction helper. The existing top and control logic reuse these.
- One sub-module, skid_fifo2: 2-entry FIFO with width parameter, push/pop/count/flush.

Test Plan:
- SPECTRAL_BANDS=10, CONCAT=4, TOTAL_PIXELS=5 (BEATS=3, 15 beats), mem word = address; out_ready=1 -> 15 beats on consecutive cycles from start+3. out_last_beat on beats 2,5,8,11,14. out_last_pixel on beats 12-14. Lanes 2,3 of every third beat = 0. pass_done one cycle after beat 14.
- Same config, out_ready random 50% -> scoreboard sees exactly addresses 0..14 in order. pixel_out is stable while stalled. FIFO count never exceeds 2.
- out_ready=0 from start -> at most 2 mem_rd_en pulses issued, out_valid=1 holding address 0; releasing ready resumes at full rate.
- abort asserted mid-pass at beat 7 under backpressure -> next cycle out_valid=0, busy=0, no pass_done. A subsequent start restarts from address 0.
- start pulsed while busy, and in the DONE cycle -> ignored; busy and counters unaffected.
- rst asserted low mid-pass, asynchronously between clock edges -> all outputs 0 immediately. After release, a start yields a full clean pass.
